// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer
// Latches one operand set on start, sweeps ALU select codes 0..NUM_OPS-1, samples each
// result after SETTLE cycles and streams (op, data) pairs out over a valid/ready handshake.
//
// Parameters:
//   NUM_OPS  select codes swept per run (1..8)
//   SETTLE   cycles ALU inputs are held before sampling (1..4)
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   start, a_in, b_in, c_in    run request and operands (accepted in IDLE only)
//   busy                       high outside IDLE
//   alu_a/b/c, alu_select      registered ALU operand and select drive
//   alu_out                    ALU result
//   res_valid/ready/data/op    result stream
//   done                       one-cycle pulse after the last result handshake
//   err                        sticky result-mismatch flag
// Optional feature: define ALU_SEQ_CHECK_EN to enable the internal ALU reference model
// that raises err on a mismatching capture; otherwise err is tied low.
module alu_op_sequencer #(
  parameter int unsigned NUM_OPS = 8,
  parameter int unsigned SETTLE  = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] a_in,
  input  logic [3:0] b_in,
  input  logic [3:0] c_in,
  output logic       busy,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  output logic [3:0] alu_c,
  output logic [2:0] alu_select,
  input  logic [5:0] alu_out,
  output logic       res_valid,
  input  logic       res_ready,
  output logic [5:0] res_data,
  output logic [2:0] res_op,
  output logic       done,
  output logic       err
);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_LOAD    = 3'd1;
  localparam logic [2:0] ST_DRIVE   = 3'd2;
  localparam logic [2:0] ST_PRESENT = 3'd3;
  localparam logic [2:0] ST_DONE    = 3'd4;

  localparam logic [2:0] LAST_OP  = 3'(NUM_OPS - 1);
  localparam logic [1:0] CNT_INIT = 2'(SETTLE - 1);
  localparam logic [2:0] SEL_PARK = 3'b111;

  logic [2:0] state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic [3:0] a_q, a_d, b_q, b_d, c_q, c_d;
  logic [2:0] sel_q, sel_d;
  logic       valid_q, valid_d;
  logic [5:0] data_q, data_d;
  logic [2:0] op_q, op_d;

  logic accept;
  logic capture;

  assign accept  = (state_q == ST_IDLE) && start;
  assign capture = (state_q == ST_DRIVE) && (cnt_q == 2'd0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    sel_d   = sel_q;
    valid_d = valid_q;
    data_d  = data_q;
    op_d    = op_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_d     = a_in;
          b_d     = b_in;
          c_d     = c_in;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        sel_d   = 3'd0;
        cnt_d   = CNT_INIT;
        state_d = ST_DRIVE;
      end
      ST_DRIVE: begin
        if (cnt_q == 2'd0) begin
          data_d  = alu_out;
          op_d    = sel_q;
          valid_d = 1'b1;
          state_d = ST_PRESENT;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      ST_PRESENT: begin
        if (res_ready) begin
          valid_d = 1'b0;
          if (op_q == LAST_OP) begin
            sel_d   = SEL_PARK;
            state_d = ST_DONE;
          end else begin
            sel_d   = sel_q + 3'd1;
            cnt_d   = CNT_INIT;
            state_d = ST_DRIVE;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= 2'd0;
      a_q     <= 4'd0;
      b_q     <= 4'd0;
      c_q     <= 4'd0;
      sel_q   <= SEL_PARK;
      valid_q <= 1'b0;
      data_q  <= 6'd0;
      op_q    <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      sel_q   <= sel_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      op_q    <= op_d;
    end
  end

`ifdef ALU_SEQ_CHECK_EN
  // Reference model of the ALU, driven from the same registers the ALU sees.
  logic [5:0] ea, eb, ec;
  logic [7:0] prod;
  logic [5:0] max_ab, min_ab, max3, min3, med3;
  logic [5:0] expected;
  logic       err_q, err_d;

  assign ea     = {2'b00, a_q};
  assign eb     = {2'b00, b_q};
  assign ec     = {2'b00, c_q};
  assign prod   = {4'b0000, a_q} * {4'b0000, b_q};
  assign max_ab = (ea > eb) ? ea : eb;
  assign min_ab = (ea < eb) ? ea : eb;
  assign max3   = (max_ab > ec) ? max_ab : ec;
  assign min3   = (min_ab < ec) ? min_ab : ec;
  // median = larger of min(a,b) and min(max(a,b), c)
  assign med3   = (min_ab > ((max_ab < ec) ? max_ab : ec)) ? min_ab
                                                            : ((max_ab < ec) ? max_ab : ec);

  always_comb begin
    expected = 6'd0;
    case (sel_q)
      3'd0:    expected = prod[5:0];
      3'd1:    expected = ea + eb;
      3'd2:    expected = ea - eb;
      3'd3:    expected = ea + 6'd1;
      3'd4:    expected = ea - 6'd1;
      3'd5:    expected = max3;
      3'd6:    expected = min3;
      default: expected = med3;
    endcase
  end

  always_comb begin
    err_d = err_q;
    if (accept) begin
      err_d = 1'b0;
    end else if (capture && (alu_out != expected)) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign busy       = (state_q != ST_IDLE);
  assign done       = (state_q == ST_DONE);
  assign alu_a      = a_q;
  assign alu_b      = b_q;
  assign alu_c      = c_q;
  assign alu_select = sel_q;
  assign res_valid  = valid_q;
  assign res_data   = data_q;
  assign res_op     = op_q;

endmodule

// File: doc/alu_op_sequencer.md
# alu_op_sequencer

Command initiator for the 3-operand, 8-function combinational ALU. It latches one operand set (a, b, c) on a start pulse and drives the ALU's operand and select ports. It sweeps select codes 0..NUM_OPS-1 and samples each ALU result, then streams every result out over a valid/ready handshake tagged with its op code. It sits between a control/test master and the ALU and is the only driver of the ALU's inputs.

## Interface
- NUM_OPS, 8, number of select codes swept per run, legal 1..8, issued in order 0..NUM_OPS-1
- SETTLE, 1, cycles the ALU inputs are held before the result is sampled, legal 1..4
- clk  input  1  sole clock, all state on rising edge
- rst_n  input  1  reset, asynchronous, active-low
- start  input  1  run request, accepted only in IDLE
- a_in, b_in, c_in  input  4 each  operands, sampled on accepted start
- busy  output  1  high in every state except IDLE
- alu_a, alu_b, alu_c  output  4 each  registered ALU operands
- alu_select  output  3  registered ALU function select
- alu_out  input  6  ALU result
- res_valid  output  1  result available
- res_ready  input  1  consumer accepts result
- res_data  output  6  captured result
- res_op  output  3  select code that produced res_data
- done  output  1  one-cycle pulse after final result handshake
- err  output  1  sticky result-mismatch flag; see Configuration

## Operation
- States: IDLE, LOAD, DRIVE, PRESENT, DONE.
- IDLE: start=1 at an edge latches a_in/b_in/c_in into alu_a/b/c and moves to LOAD. alu_select stays parked at 3'b111.
- LOAD: one cycle with operands stable. At the next edge, alu_select=0, the settle counter is loaded with SETTLE-1, and the FSM moves to DRIVE.
- DRIVE: the counter decrements each edge. On the edge where it is 0, alu_out is captured into res_data, alu_select into res_op, res_valid is set, and the FSM moves to PRESENT.
- PRESENT: res_valid, res_data and res_op are held stable until res_valid && res_ready at an edge. On that edge:
  - if res_op == NUM_OPS-1: move to DONE and clear res_valid;
  - otherwise: alu_select+1, reload the counter, move to DRIVE and clear res_valid.
- DONE: done=1 for exactly this cycle; alu_select parks at 3'b111; return to IDLE.
- alu_select changes value on every issue (park 7 to 0, then n to n+1). Operands never change during a run.
- start in any state other than IDLE is ignored and not queued.
- res_data/res_op keep their last value after the handshake until the next capture.
- ALU contract for the expected model, all results 6-bit:
  - 0: a*b, low 6 bits
  - 1: a+b
  - 2: a-b mod 64
  - 3: a+1
  - 4: a-1 mod 64
  - 5: max(a,b,c)
  - 6: min(a,b,c)
  - 7: median(a,b,c), zero-extended

## Timing
- Reset (async assert, sync-safe deassert) forces:
  - state IDLE
  - busy=0, res_valid=0, done=0, err=0
  - alu_a=alu_b=alu_c=0, alu_select=3'b111
  - res_data=0, res_op=0
- Reset mid-run aborts immediately: no done pulse, and the partial stream is discarded.
- Start accepted at edge k: busy=1 after k, alu_select=0 after k+1, res_valid=1 after k+1+SETTLE.
- With res_ready held high, each result is one cycle valid, then SETTLE cycles of DRIVE. Op-to-op spacing is 1+SETTLE cycles.
- Total run, start edge to done high: 1 + NUM_OPS*(1+SETTLE) edges minimum.
- Backpressure: res_ready low stalls indefinitely in PRESENT with all outputs frozen.
- res_ready while res_valid=0 has no effect.

## Configuration
- ALU_SEQ_CHECK_EN defined:
  - An internal model computes the expected value from the latched operands and alu_select, using the ALU contract above.
  - At each capture edge where alu_out differs from the expected value, err sets.
  - err is sticky until reset or the next accepted start clears it.
- Not defined: the model is absent and err is tied 0.

## Test plan
- a=3,b=5,c=1, NUM_OPS=8, SETTLE=1, real ALU, res_ready=1 -> stream (op,data) = (0,15),(1,8),(2,62),(3,4),(4,2),(5,5),(6,1),(7,3); res_valid first high 3 edges after start; done 1 cycle after last handshake; err=0.
- a=15,b=15,c=15 -> op0=33, op1=30, op2=0, op5..7=15. Then a=0,b=1,c=2 -> op2=63, op4=63, op7=1.
- res_ready low 5 cycles while op2 is presented -> res_valid, res_data, res_op stable throughout; op3 appears SETTLE+1 cycles after res_ready rises.
- start pulsed during DRIVE and during DONE -> ignored; exactly NUM_OPS results per run; the next start from IDLE is accepted.
- rst_n low during op4's DRIVE -> all outputs at reset values asynchronously, no done pulse, alu_select=7.
- ALU_SEQ_CHECK_EN, alu_out forced to 0 on op1 with a=2,b=2 -> err=1 from that capture and held; the next accepted start clears it to 0.
